// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle LA32R control FSM.
//   - state_e     : FSM state encoding, also exported on state_o for debug
//   - range limits: legal MEM_LAT / TIMEOUT ranges, used to clamp parameters
//   - wait_width  : wait-counter width for the selected SRAM completion mode
package mc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RST  = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EXE  = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd7
  } state_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int TIMEOUT_MIN = 1;
  localparam int TIMEOUT_MAX = 255;

  // Fixed latency needs 4 bits (up to 15); the handshake timeout needs 8 (up to 255).
  localparam int WAIT_W_LAT = 4;
  localparam int WAIT_W_HS  = 8;

  function automatic int wait_width(input int mem_hs);
    return (mem_hs != 0) ? WAIT_W_HS : WAIT_W_LAT;
  endfunction

  // Out-of-range parameters are pulled back into the legal range.
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) begin
      return lo;
    end else if (v > hi) begin
      return hi;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: counts cycles spent in the current wait state.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : restart from 0 (asserted on every state change)
//   done_o     : this is the DONE_AT-th cycle of the wait (fixed latency reached)
//   expire_o   : this is the EXPIRE_AT-th cycle of the wait (timeout reached)
// The count saturates so a long stall never wraps back into a false match.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int W         = WAIT_W_HS,
  parameter int DONE_AT   = 1,
  parameter int EXPIRE_AT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic done_o,
  output logic expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment.
  always_comb begin
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q != {W{1'b1}}) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q is 0 in the first wait cycle, so N cycles have elapsed when it equals N-1.
  assign done_o   = (cnt_q == W'(DONE_AT - 1));
  assign expire_o = (cnt_q == W'(EXPIRE_AT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: control sequencer of the multi-cycle LA32R core (IF/ID/EXE/MEM/WB).
//   clk, resetn              : clock, async active-low reset
//   inst_req / inst_ack      : instruction SRAM handshake
//   data_req / data_we / data_ack : data SRAM handshake, data_we marks a store
//   dec_*                    : instruction class flags from the decoder
//   ir_we, pc_we, pc_sel_br, rf_we : datapath enables
//   retire                   : one pulse per completed instruction
//   halted, err_timeout      : halt status, sticky ack-timeout flag
//   state_o                  : current state (debug)
//   cnt_cycle, cnt_retire    : active-cycle and retired-instruction counters
// Controls are decodes of the registered state (plus acks/decoder flags for the
// Mealy strobes), so reset drops every request asynchronously.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int MEM_HS  = 1,
  parameter int MEM_LAT = 1,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_req,
  input  logic             inst_ack,
  output logic             data_req,
  output logic             data_we,
  input  logic             data_ack,
  input  logic             dec_illegal,
  input  logic             dec_br_only,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_gr_we,
  input  logic             dec_br_taken,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             rf_we,
  output logic             retire,
  output logic             halted,
  output logic             err_timeout,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cnt_cycle,
  output logic [CNT_W-1:0] cnt_retire
);

  localparam int LAT_C  = clamp_int(MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
  localparam int TMO_C  = clamp_int(TIMEOUT, TIMEOUT_MIN, TIMEOUT_MAX);
  localparam int WAIT_W = wait_width(MEM_HS);
  localparam bit HS     = (MEM_HS != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q;
  state_e           state_d;
  logic             err_timeout_q;
  logic             timeout_hit_s;
  logic [CNT_W-1:0] cnt_cycle_q;
  logic [CNT_W-1:0] cnt_retire_q;
  logic             tmr_clr_s;
  logic             tmr_done_s;
  logic             tmr_expire_s;
  logic             ack_sel_s;
  logic             acc_done_s;
  logic             acc_expire_s;

  // The timer restarts on every state change, so it always measures the current wait.
  assign tmr_clr_s = (state_d != state_q);

  mc_wait_timer #(
    .W        (WAIT_W),
    .DONE_AT  (LAT_C),
    .EXPIRE_AT(TMO_C)
  ) u_wait (
    .clk     (clk),
    .rst_n   (resetn),
    .clr_i   (tmr_clr_s),
    .done_o  (tmr_done_s),
    .expire_o(tmr_expire_s)
  );

  // Only the ack of the port being waited on matters; acks are not looked at elsewhere.
  assign ack_sel_s    = (state_q == ST_MEM) ? data_ack : inst_ack;
  assign acc_done_s   = HS ? ack_sel_s : tmr_done_s;
  // Checked after acc_done_s in the FSM, so an ack on the expiry cycle wins.
  assign acc_expire_s = HS & tmr_expire_s;

  // Next-state and control decode.
  always_comb begin
    state_d       = state_q;
    inst_req      = 1'b0;
    data_req      = 1'b0;
    data_we       = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_sel_br     = 1'b0;
    rf_we         = 1'b0;
    retire        = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_IF;
      end
      ST_IF: begin
        inst_req = 1'b1;
        if (acc_done_s) begin
          ir_we   = 1'b1;
          state_d = ST_ID;
        end else if (acc_expire_s) begin
          timeout_hit_s = 1'b1;
          state_d       = ST_HALT;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_ID: begin
        if (dec_illegal) begin
          state_d = ST_HALT;
        end else if (dec_br_only) begin
          pc_we     = 1'b1;
          pc_sel_br = dec_br_taken;
          retire    = 1'b1;
          state_d   = ST_IF;
        end else begin
          state_d = ST_EXE;
        end
      end
      ST_EXE: begin
        if (dec_load | dec_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        data_req = 1'b1;
        data_we  = dec_store;
        if (acc_done_s) begin
          if (dec_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else if (acc_expire_s) begin
          timeout_hit_s = 1'b1;
          state_d       = ST_HALT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we     = dec_gr_we;
        pc_we     = 1'b1;
        pc_sel_br = dec_br_taken;
        retire    = 1'b1;
        state_d   = ST_IF;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        // Unused encoding: park safely.
        state_d = ST_HALT;
      end
    endcase
  end

  // State register and sticky timeout flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_RST;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      err_timeout_q <= err_timeout_q | timeout_hit_s;
    end
  end

  // Performance counters: active cycles (frozen in RST/HALT) and retirements, both wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_cycle_q  <= '0;
      cnt_retire_q <= '0;
    end else begin
      if (state_q inside {ST_IF, ST_ID, ST_EXE, ST_MEM, ST_WB}) begin
        cnt_cycle_q <= cnt_cycle_q + CNT_ONE;
      end else begin
        cnt_cycle_q <= cnt_cycle_q;
      end
      if (retire) begin
        cnt_retire_q <= cnt_retire_q + CNT_ONE;
      end else begin
        cnt_retire_q <= cnt_retire_q;
      end
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign err_timeout = err_timeout_q;
  assign state_o     = state_q;
  assign cnt_cycle   = cnt_cycle_q;
  assign cnt_retire  = cnt_retire_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: random instruction streams against a per-instruction
// reference (expected cycles, request lengths, strobes, counters) for a
// handshake instance (TIMEOUT=4, CNT_W=4) and a fixed-latency instance (LAT=2).
module tb_mc_ctrl_fsm;

  localparam int K_ALU = 0;
  localparam int K_BR  = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_ILL = 4;
  localparam int TMO   = 4;
  localparam int FLAT  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // handshake instance
  logic       resetn, inst_ack, data_ack;
  logic       dec_illegal, dec_br_only, dec_load, dec_store, dec_gr_we, dec_br_taken;
  logic       inst_req, data_req, data_we, ir_we, pc_we, pc_sel_br, rf_we, retire, halted, err_timeout;
  logic [2:0] state_o;
  logic [3:0] cnt_cycle, cnt_retire;

  // fixed-latency instance
  logic       resetn_f, inst_ack_f, data_ack_f;
  logic       dec_illegal_f, dec_br_only_f, dec_load_f, dec_store_f, dec_gr_we_f, dec_br_taken_f;
  logic       inst_req_f, data_req_f, data_we_f, ir_we_f, pc_we_f, pc_sel_br_f, rf_we_f, retire_f;
  logic       halted_f, err_timeout_f;
  logic [2:0] state_o_f;
  logic [7:0] cnt_cycle_f, cnt_retire_f;

  mc_ctrl_fsm #(.MEM_HS(1), .MEM_LAT(1), .TIMEOUT(TMO), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_ack(inst_ack),
    .data_req(data_req), .data_we(data_we), .data_ack(data_ack),
    .dec_illegal(dec_illegal), .dec_br_only(dec_br_only), .dec_load(dec_load),
    .dec_store(dec_store), .dec_gr_we(dec_gr_we), .dec_br_taken(dec_br_taken),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel_br(pc_sel_br), .rf_we(rf_we), .retire(retire),
    .halted(halted), .err_timeout(err_timeout), .state_o(state_o),
    .cnt_cycle(cnt_cycle), .cnt_retire(cnt_retire)
  );

  mc_ctrl_fsm #(.MEM_HS(0), .MEM_LAT(FLAT), .TIMEOUT(255), .CNT_W(8)) dut_f (
    .clk(clk), .resetn(resetn_f), .inst_req(inst_req_f), .inst_ack(inst_ack_f),
    .data_req(data_req_f), .data_we(data_we_f), .data_ack(data_ack_f),
    .dec_illegal(dec_illegal_f), .dec_br_only(dec_br_only_f), .dec_load(dec_load_f),
    .dec_store(dec_store_f), .dec_gr_we(dec_gr_we_f), .dec_br_taken(dec_br_taken_f),
    .ir_we(ir_we_f), .pc_we(pc_we_f), .pc_sel_br(pc_sel_br_f), .rf_we(rf_we_f), .retire(retire_f),
    .halted(halted_f), .err_timeout(err_timeout_f), .state_o(state_o_f),
    .cnt_cycle(cnt_cycle_f), .cnt_retire(cnt_retire_f)
  );

  int checks = 0;
  int errors = 0;
  int m_cycle, m_retire, mf_cycle, mf_retire;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // {illegal, br_only, load, store, gr_we, br_taken} as a decoder would present them
  function automatic logic [5:0] dec_vec(input int k, input bit tk, input bit gw);
    return {k == K_ILL, k == K_BR, k == K_LD, k == K_ST, gw, tk};
  endfunction

  // Instruction length: fetch, decode, then execute / memory / writeback as the class needs.
  function automatic int exp_cycles(input int k, input int li, input int lm);
    if (k == K_BR) return li + 1;
    if (k == K_ST) return li + 2 + lm;
    if (k == K_LD) return li + 3 + lm;
    return li + 3;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; inst_ack = 1'b0; data_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {inst_req, data_req, data_we, ir_we, pc_we, pc_sel_br, rf_we, retire,
                        halted, err_timeout, state_o, cnt_cycle, cnt_retire}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_to_if", state_o, 32'd1);
    m_cycle = 0; m_retire = 0;
  endtask

  // di/dd: request cycle on which the ack is returned, 0 = never.
  task automatic run_main(input int k, input int di, input int dd, input bit tk, input bit gw);
    int  ireq, dreq, rfw, pcw, ret, cyc, irw, bad_we, n;
    int  e_cyc, e_ireq, e_dreq, e_rfw, e_ret, e_irw;
    bit  sel, done, e_halt, e_tmo, e_sel, mem;
    ireq = 0; dreq = 0; rfw = 0; pcw = 0; ret = 0; cyc = 0; irw = 0; bad_we = 0;
    sel = 1'b0; done = 1'b0; n = 0;
    mem = (k == K_LD) || (k == K_ST);
    {dec_illegal, dec_br_only, dec_load, dec_store, dec_gr_we, dec_br_taken} = dec_vec(k, tk, gw);
    e_halt = 1'b0; e_tmo = 1'b0; e_dreq = 0; e_rfw = 0; e_ret = 1; e_sel = tk; e_ireq = di;
    e_irw = (di != 0) ? 1 : 0;
    if (di == 0) begin
      e_ireq = TMO; e_cyc = TMO; e_halt = 1'b1; e_tmo = 1'b1; e_ret = 0;
    end else if (k == K_ILL) begin
      e_cyc = di + 1; e_halt = 1'b1; e_ret = 0;
    end else if (mem && dd == 0) begin
      e_cyc = di + 2 + TMO; e_dreq = TMO; e_halt = 1'b1; e_tmo = 1'b1; e_ret = 0;
    end else begin
      e_cyc  = exp_cycles(k, di, dd);
      e_dreq = mem ? dd : 0;
      e_rfw  = (k == K_ALU || k == K_LD) ? int'(gw) : 0;
      e_sel  = (k == K_ST) ? 1'b0 : tk;
    end
    while (!done && n < 64) begin
      inst_ack = inst_req ? ((di != 0) && (ireq + 1 == di)) : 1'($urandom_range(0, 1));
      data_ack = data_req ? ((dd != 0) && (dreq + 1 == dd)) : 1'($urandom_range(0, 1));
      #1;
      if (halted) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (inst_req) ireq++;
        if (data_req) dreq++;
        if (data_req && (data_we !== dec_store)) bad_we++;
        if (ir_we) irw++;
        if (rf_we) rfw++;
        if (pc_we) begin pcw++; sel = pc_sel_br; end
        if (retire) begin ret++; done = 1'b1; end
        @(negedge clk);
      end
      n++;
    end
    inst_ack = 1'b0; data_ack = 1'b0;
    chk("insn_completed", done, 32'd1);
    chk("cycles", cyc, e_cyc);
    chk("inst_req_cycles", ireq, e_ireq);
    chk("data_req_cycles", dreq, e_dreq);
    chk("ir_we_pulses", irw, e_irw);
    chk("rf_we_pulses", rfw, e_rfw);
    chk("pc_we_pulses", pcw, e_ret);
    if (e_ret != 0) chk("pc_sel_br", sel, e_sel);
    chk("retire_pulses", ret, e_ret);
    chk("data_we_bad", bad_we, 32'd0);
    chk("halted", halted, e_halt);
    chk("err_timeout", err_timeout, e_tmo);
    m_cycle  += e_cyc;
    m_retire += e_ret;
    chk("cnt_cycle", cnt_cycle, m_cycle % 16);
    chk("cnt_retire", cnt_retire, m_retire % 16);
  endtask

  task automatic run_fl(input int k, input bit tk, input bit gw);
    int ireq, dreq, rfw, pcw, ret, cyc, n, e_cyc, e_rfw;
    bit sel, done, mem;
    ireq = 0; dreq = 0; rfw = 0; pcw = 0; ret = 0; cyc = 0; n = 0;
    sel = 1'b0; done = 1'b0;
    mem = (k == K_LD) || (k == K_ST);
    {dec_illegal_f, dec_br_only_f, dec_load_f, dec_store_f, dec_gr_we_f, dec_br_taken_f} = dec_vec(k, tk, gw);
    e_cyc = exp_cycles(k, FLAT, FLAT);
    e_rfw = (k == K_ALU || k == K_LD) ? int'(gw) : 0;
    while (!done && n < 64) begin
      // acks are meaningless in fixed-latency mode
      inst_ack_f = 1'($urandom_range(0, 1));
      data_ack_f = 1'($urandom_range(0, 1));
      #1;
      cyc++;
      if (inst_req_f) ireq++;
      if (data_req_f) dreq++;
      if (rf_we_f) rfw++;
      if (pc_we_f) begin pcw++; sel = pc_sel_br_f; end
      if (retire_f) begin ret++; done = 1'b1; end
      @(negedge clk);
      n++;
    end
    chk("f_insn_completed", done, 32'd1);
    chk("f_cycles", cyc, e_cyc);
    chk("f_inst_req_cycles", ireq, FLAT);
    chk("f_data_req_cycles", dreq, mem ? FLAT : 0);
    chk("f_rf_we_pulses", rfw, e_rfw);
    chk("f_pc_we_pulses", pcw, 32'd1);
    chk("f_pc_sel_br", sel, (k == K_ST) ? 1'b0 : tk);
    chk("f_retire_pulses", ret, 32'd1);
    mf_cycle  += e_cyc;
    mf_retire += 1;
    chk("f_cnt_cycle", cnt_cycle_f, mf_cycle % 256);
    chk("f_cnt_retire", cnt_retire_f, mf_retire % 256);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; inst_ack = 1'b0; data_ack = 1'b0;
    {dec_illegal, dec_br_only, dec_load, dec_store, dec_gr_we, dec_br_taken} = 6'd0;
    resetn_f = 1'b0; inst_ack_f = 1'b0; data_ack_f = 1'b0;
    {dec_illegal_f, dec_br_only_f, dec_load_f, dec_store_f, dec_gr_we_f, dec_br_taken_f} = 6'd0;

    // fixed-latency instance
    repeat (2) @(negedge clk);
    chk("f_rst_outputs", {inst_req_f, data_req_f, retire_f, halted_f, state_o_f, cnt_cycle_f, cnt_retire_f}, 32'd0);
    resetn_f = 1'b1;
    @(negedge clk);
    mf_cycle = 0; mf_retire = 0;
    run_fl(K_ALU, 1'b0, 1'b1);
    run_fl(K_LD, 1'b0, 1'b1);
    run_fl(K_ST, 1'b0, 1'b0);
    run_fl(K_BR, 1'b1, 1'b0);
    run_fl(K_BR, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      run_fl(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // handshake instance: directed cases then random stream
    do_reset();
    run_main(K_ALU, 1, 0, 1'b0, 1'b1);      // 4 cycles
    run_main(K_LD, 3, 2, 1'b0, 1'b1);       // 8 cycles
    run_main(K_BR, 1, 0, 1'b1, 1'b0);       // beq taken
    run_main(K_BR, 1, 0, 1'b0, 1'b1);       // bne not taken, gr_we ignored
    run_main(K_ST, 2, TMO, 1'b0, 1'b0);     // ack on the expiry cycle wins
    run_main(K_ALU, TMO, 0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run_main(int'($urandom_range(0, 3)), int'($urandom_range(1, TMO)), int'($urandom_range(1, TMO)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // 16 retirements wrap a 4-bit counter
    do_reset();
    for (int i = 0; i < 16; i++) run_main(K_ALU, 1, 0, 1'b0, 1'b1);
    chk("retire_wrap", cnt_retire, 32'd0);

    // data ack timeout, then halt is frozen and deaf to acks
    run_main(K_LD, 2, 0, 1'b0, 1'b1);
    inst_ack = 1'b1; data_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("halt_state", state_o, 32'd7);
    chk("halt_quiet", {inst_req, data_req, ir_we, pc_we, rf_we, retire}, 32'd0);
    chk("halt_cnt_cycle", cnt_cycle, m_cycle % 16);
    chk("halt_cnt_retire", cnt_retire, m_retire % 16);
    inst_ack = 1'b0; data_ack = 1'b0;

    // fetch ack timeout
    do_reset();
    run_main(K_ALU, 0, 0, 1'b0, 1'b1);

    // illegal instruction
    do_reset();
    run_main(K_ALU, 1, 0, 1'b0, 1'b1);
    run_main(K_ILL, 2, 0, 1'b0, 1'b0);

    // reset in the middle of a load's data access
    do_reset();
    {dec_illegal, dec_br_only, dec_load, dec_store, dec_gr_we, dec_br_taken} = dec_vec(K_LD, 1'b0, 1'b1);
    inst_ack = 1'b1;
    @(negedge clk);
    inst_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_mem_req", data_req, 32'd1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_outputs", {inst_req, data_req, data_we, retire, state_o}, 32'd0);
    chk("abort_no_retire", cnt_retire, 32'd0);
    do_reset();
    run_main(K_ALU, 1, 0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
